// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/busy/done and HI/LO result bundle for mult_div_unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, op_a, op_b,
    input  busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, op_a, op_b,
    output busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO register block
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [4:0]       count;
  logic             fix_phase;
  logic [1:0]       op_r;
  logic             sign_a;
  logic             sign_b;
  logic             b_zero;
  logic [WIDTH-1:0] orig_a;
  logic [WIDTH-1:0] operand;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic             in_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [W2-1:0]    div_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [W2-1:0]    fixed;

  // Operand magnitudes; unsigned ops pass raw values through
  assign in_signed = ~bus.op[0];
  assign a_neg     = in_signed & bus.op_a[WIDTH-1];
  assign b_neg     = in_signed & bus.op_b[WIDTH-1];
  assign a_mag     = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
  assign b_mag     = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
  assign is_div    = op_r[1];

  // Shift-add step: acc holds {partial product, remaining multiplier}
  assign mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: acc holds {remainder, quotient/dividend}
  assign rem_sh   = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, operand};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};

  assign quo_fix = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix = sign_a ? (~acc[W2-1:WIDTH] + 1'b1) : acc[W2-1:WIDTH];

  always_comb begin
    fixed = acc;
    if (is_div) begin
      if (b_zero)
        fixed = {orig_a, {WIDTH{1'b1}}};
      else
        fixed = {rem_fix, quo_fix};
    end else if (sign_a ^ sign_b) begin
      fixed = ~acc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (count == 5'(WIDTH - 1)) state_nxt = FIX;
      FIX:  if (fix_phase) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIX spans two edges: correct the accumulator, then publish it on entry to DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      fix_phase <= 1'b0;
      op_r      <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      orig_a    <= '0;
      operand   <= '0;
      acc       <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r      <= bus.op;
            sign_a    <= a_neg;
            sign_b    <= b_neg;
            b_zero    <= (bus.op_b == '0);
            orig_a    <= bus.op_a;
            count     <= '0;
            fix_phase <= 1'b0;
            if (bus.op[1]) begin
              operand <= b_mag;
              acc     <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              operand <= a_mag;
              acc     <= {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
        RUN: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 5'd1;
        end
        FIX: begin
          if (!fix_phase) begin
            acc       <= fixed;
            fix_phase <= 1'b1;
          end else begin
            hi_r <= acc[W2-1:WIDTH];
            lo_r <= acc[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == RUN) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized and directed bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass = 0;

  mult_div_unit_if #(.WIDTH(32)) bus();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (o)
      2'b00: begin sp = sa * sb; r = sp; end
      2'b01: begin up = ua * ub; r = up; end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          r = {sr[31:0], sq[31:0]};
        end else begin
          uq = ua / ub; ur = ua % ub;
          r = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; start is sampled at the following posedge (edge E)
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, output int lat, output int bcnt,
                       output logic [63:0] mid, output logic [63:0] res);
    bus.start = 1'b1; bus.op = o; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
    lat = 0; bcnt = 0; mid = '0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) bcnt++;
      if (lat == 17) mid = {bus.hi_out, bus.lo_out};
      if (inject && (lat == 5 || lat == 20)) begin
        bus.start = 1'b1; bus.op = 2'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    res = {bus.hi_out, bus.lo_out};
  endtask

  vec_t        dir[9];
  int          lat, bcnt, dn;
  logic [63:0] mid, res, prev;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    dir[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    dir[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    dir[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    dir[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    dir[4] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dir[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    dir[6] = '{2'b10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    dir[7] = '{2'b11, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF};
    dir[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};

    reset = 1'b1; bus.start = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    prev = '0;
    for (int i = 0; i < 9; i++) begin
      do_op(dir[i].op, dir[i].a, dir[i].b, 1'b0, lat, bcnt, mid, res);
      check($sformatf("dir%0d_result", i), res, {dir[i].hi, dir[i].lo});
      check($sformatf("dir%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("dir%0d_busy_cycles", i), 64'(bcnt), 64'd34);
      check($sformatf("dir%0d_hold", i), mid, prev);
      prev = res;
      @(negedge clk);
      check($sformatf("dir%0d_done_once", i), {63'd0, bus.done}, 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom); ra = pick(); rb = pick();
      do_op(ro, ra, rb, 1'b0, lat, bcnt, mid, res);
      check($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), res, model(ro, ra, rb));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd34);
      @(negedge clk);
    end

    // Starts during RUN are ignored
    do_op(2'b01, 32'd3, 32'd5, 1'b1, lat, bcnt, mid, res);
    check("ignore_busy_result", res, {32'd0, 32'd15});
    check("ignore_busy_latency", 64'(lat), 64'd34);

    // Start in the DONE cycle is ignored; start in the following cycle is accepted
    bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    check("done_start_ignored", {63'd0, bus.busy}, 64'd0);
    do_op(2'b11, 32'd1000, 32'd33, 1'b0, lat, bcnt, mid, res);
    check("b2b_result", res, model(2'b11, 32'd1000, 32'd33));
    check("b2b_latency", 64'(lat), 64'd34);
    @(negedge clk);

    // Reset mid-operation
    bus.start = 1'b1; bus.op = 2'b11; bus.op_a = 32'd100; bus.op_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", 64'(dn), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
